redirect_fwd_ctrl: RTL and testbench

Parametrised successor to the pipeline control block. It resolves control-flow redirects from EXU: jump, taken branch, mret, ecall and fence.i. Each redirect is held in a registered request until fetch accepts it over a valid/ready handshake, and fence.i runs an explicit icache-flush handshake first. It also provides an N-source operand forwarding network with load-use stall detection for IDU→EXU operands.

---
 rtl/redirect_fwd_ctrl.sv | 135 +++++++++++++
 tb/tb_redirect_fwd_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redirect_fwd_ctrl.sv
// redirect_fwd_ctrl: resolves EXU control-flow redirects (jump, taken branch,
// mret, ecall, fence.i) into a held valid/ready request towards fetch, with an
// icache-flush handshake ahead of fence.i redirects. Also hosts the IDU->EXU
// operand forwarding network and load-use stall detection.
module redirect_fwd_ctrl #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3,
  parameter int RA_W    = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ex_valid,
  input  logic [XLEN-1:0]         ex_pc,
  input  logic                    ex_jump_flag,
  input  logic                    ex_branch_flag,
  input  logic                    ex_branch_taken,
  input  logic                    ex_mret_flag,
  input  logic                    ex_ecall_flag,
  input  logic                    ex_fence_i_flag,
  input  logic [XLEN-1:0]         ex_jump_target,
  input  logic [XLEN-1:0]         ex_branch_target,
  input  logic [XLEN-1:0]         mtvec,
  input  logic [XLEN-1:0]         mepc,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  input  logic                    redirect_ready,
  output logic                    flush,
  output logic                    icache_clr_req,
  input  logic                    icache_clr_done,
  output logic                    busy,
  input  logic                    id_valid,
  input  logic [RA_W-1:0]         id_rs1,
  input  logic [RA_W-1:0]         id_rs2,
  input  logic [XLEN-1:0]         id_rs1_value,
  input  logic [XLEN-1:0]         id_rs2_value,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_wen,
  input  logic [NUM_FWD-1:0]      fwd_data_rdy,
  input  logic [NUM_FWD*RA_W-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  output logic [XLEN-1:0]         exu_rs1_in,
  output logic [XLEN-1:0]         exu_rs2_in,
  output logic                    id_stall
);

  typedef enum logic [1:0] {IDLE, ICFLUSH, REDIR} state_t;

  state_t          state;
  state_t          next_state;
  logic            ev_any;
  logic            ev_is_fence;
  logic [XLEN-1:0] ev_target;
  logic            accept;
  logic            rs1_not_rdy;
  logic            rs2_not_rdy;

  // Event decode: priority jump > taken branch > mret > ecall > fence.i
  always_comb begin
    ev_any      = 1'b1;
    ev_is_fence = 1'b0;
    ev_target   = '0;
    if (ex_jump_flag) begin
      ev_target = ex_jump_target;
    end else if (ex_branch_flag && ex_branch_taken) begin
      ev_target = ex_branch_target;
    end else if (ex_mret_flag) begin
      ev_target = mepc;
    end else if (ex_ecall_flag) begin
      ev_target = mtvec;
    end else if (ex_fence_i_flag) begin
      ev_is_fence = 1'b1;
      ev_target   = ex_pc + XLEN'(4);
    end else begin
      ev_any = 1'b0;
    end
    accept = (state == IDLE) && ex_valid && ev_any;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Redirect target is captured once, at acceptance, and held through the handshake
  always_ff @(posedge clock) begin
    if (reset)       redirect_pc <= '0;
    else if (accept) redirect_pc <= ev_target;
  end

  // Next-state: done/ready only matter in the state that waits for them
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ev_is_fence ? ICFLUSH : REDIR;
      ICFLUSH: if (icache_clr_done) next_state = REDIR;
      REDIR:   if (redirect_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs; flush is suppressed while reset is asserted
  always_comb begin
    redirect_valid = (state == REDIR);
    icache_clr_req = (state == ICFLUSH);
    busy           = (state != IDLE);
    flush          = accept && !reset;
  end

  // Forwarding: scan oldest to youngest so the youngest matching stage wins
  always_comb begin
    exu_rs1_in  = id_rs1_value;
    exu_rs2_in  = id_rs2_value;
    rs1_not_rdy = 1'b0;
    rs2_not_rdy = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_wen[i] && (id_rs1 != '0) &&
          (fwd_rd[i*RA_W +: RA_W] == id_rs1)) begin
        rs1_not_rdy = !fwd_data_rdy[i];
        exu_rs1_in  = fwd_data_rdy[i] ? fwd_data[i*XLEN +: XLEN] : id_rs1_value;
      end
      if (fwd_valid[i] && fwd_wen[i] && (id_rs2 != '0) &&
          (fwd_rd[i*RA_W +: RA_W] == id_rs2)) begin
        rs2_not_rdy = !fwd_data_rdy[i];
        exu_rs2_in  = fwd_data_rdy[i] ? fwd_data[i*XLEN +: XLEN] : id_rs2_value;
      end
    end
  end

  // Stall on load-use hazard or while a redirect is outstanding
  always_comb begin
    id_stall = !reset && ((id_valid && (rs1_not_rdy || rs2_not_rdy)) || busy);
  end

endmodule

// File: tb/tb_redirect_fwd_ctrl.sv
// Directed bench for redirect_fwd_ctrl with a transaction-level reference model
// compared on every falling edge, plus hand-computed literal expectations.
module tb_redirect_fwd_ctrl;
  localparam int XLEN = 32;
  localparam int NF   = 3;
  localparam int RW   = 5;

  logic            clock = 1'b0;
  logic            reset;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_jump_flag, ex_branch_flag, ex_branch_taken;
  logic            ex_mret_flag, ex_ecall_flag, ex_fence_i_flag;
  logic [XLEN-1:0] ex_jump_target, ex_branch_target, mtvec, mepc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flush, icache_clr_req, icache_clr_done, busy;
  logic            id_valid;
  logic [RW-1:0]   id_rs1, id_rs2;
  logic [XLEN-1:0] id_rs1_value, id_rs2_value;
  logic [NF-1:0]   fwd_valid, fwd_wen, fwd_data_rdy;
  logic [NF*RW-1:0]   fwd_rd;
  logic [NF*XLEN-1:0] fwd_data;
  logic [XLEN-1:0] exu_rs1_in, exu_rs2_in;
  logic            id_stall;

  int total = 0;
  int bad   = 0;

  redirect_fwd_ctrl #(.XLEN(XLEN), .NUM_FWD(NF), .RA_W(RW)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_jump_flag(ex_jump_flag), .ex_branch_flag(ex_branch_flag),
    .ex_branch_taken(ex_branch_taken), .ex_mret_flag(ex_mret_flag),
    .ex_ecall_flag(ex_ecall_flag), .ex_fence_i_flag(ex_fence_i_flag),
    .ex_jump_target(ex_jump_target), .ex_branch_target(ex_branch_target),
    .mtvec(mtvec), .mepc(mepc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .flush(flush),
    .icache_clr_req(icache_clr_req), .icache_clr_done(icache_clr_done),
    .busy(busy), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_value(id_rs1_value), .id_rs2_value(id_rs2_value),
    .fwd_valid(fwd_valid), .fwd_wen(fwd_wen), .fwd_data_rdy(fwd_data_rdy),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .exu_rs1_in(exu_rs1_in),
    .exu_rs2_in(exu_rs2_in), .id_stall(id_stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit        started = 0;
  bit        m_wait_ic = 0;     // waiting for icache invalidate
  bit        m_wait_fetch = 0;  // waiting for fetch to take the redirect
  logic [31:0] m_pc = '0;

  function automatic void event_model(output bit hit, output bit is_fence,
                                      output logic [31:0] tgt);
    hit = ex_valid; is_fence = 0; tgt = '0;
    if (!ex_valid)                        hit = 0;
    else if (ex_jump_flag)                tgt = ex_jump_target;
    else if (ex_branch_flag && ex_branch_taken) tgt = ex_branch_target;
    else if (ex_mret_flag)                tgt = mepc;
    else if (ex_ecall_flag)               tgt = mtvec;
    else if (ex_fence_i_flag) begin       tgt = ex_pc + 32'd4; is_fence = 1; end
    else                                  hit = 0;
  endfunction

  function automatic void fwd_model(input logic [RW-1:0] rs, input logic [31:0] rf,
                                    output logic [31:0] val, output bit not_rdy);
    bit found = 0;
    val = rf; not_rdy = 0;
    if (rs != 0) begin
      for (int i = 0; i < NF; i++) begin
        if (!found && fwd_valid[i] && fwd_wen[i] && fwd_rd[i*RW +: RW] == rs) begin
          found = 1;
          if (fwd_data_rdy[i]) val = fwd_data[i*XLEN +: XLEN];
          else not_rdy = 1;
        end
      end
    end
  endfunction

  always @(posedge clock) begin
    bit hit, isf;
    logic [31:0] tgt;
    started = 1;
    event_model(hit, isf, tgt);
    if (reset) begin
      m_wait_ic = 0; m_wait_fetch = 0; m_pc = '0;
    end else if (m_wait_fetch) begin
      if (redirect_ready) m_wait_fetch = 0;
    end else if (m_wait_ic) begin
      if (icache_clr_done) begin m_wait_ic = 0; m_wait_fetch = 1; end
    end else if (hit) begin
      m_pc = tgt;
      if (isf) m_wait_ic = 1; else m_wait_fetch = 1;
    end
  end

  always @(negedge clock) begin
    bit hit, isf, nr1, nr2, m_busy;
    logic [31:0] tgt, v1, v2;
    if (started) begin
      event_model(hit, isf, tgt);
      fwd_model(id_rs1, id_rs1_value, v1, nr1);
      fwd_model(id_rs2, id_rs2_value, v2, nr2);
      m_busy = m_wait_ic || m_wait_fetch;
      chk("model_redirect_valid", redirect_valid, m_wait_fetch);
      chk("model_redirect_pc", redirect_pc, m_pc);
      chk("model_icache_clr_req", icache_clr_req, m_wait_ic);
      chk("model_busy", busy, m_busy);
      chk("model_flush", flush, !reset && !m_busy && hit);
      chk("model_exu_rs1_in", exu_rs1_in, v1);
      chk("model_exu_rs2_in", exu_rs2_in, v2);
      chk("model_id_stall", id_stall, !reset && ((id_valid && (nr1 || nr2)) || m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_stage(input int i, input bit v, input bit w, input bit r,
                           input logic [RW-1:0] rd, input logic [31:0] d);
    fwd_valid[i] = v; fwd_wen[i] = w; fwd_data_rdy[i] = r;
    fwd_rd[i*RW +: RW] = rd; fwd_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic clear_ev();
    ex_valid = 0; ex_jump_flag = 0; ex_branch_flag = 0; ex_branch_taken = 0;
    ex_mret_flag = 0; ex_ecall_flag = 0; ex_fence_i_flag = 0;
  endtask

  initial begin
    reset = 1; clear_ev();
    ex_pc = '0; ex_jump_target = '0; ex_branch_target = '0;
    mtvec = 32'h0000_0040; mepc = 32'h0000_0080;
    redirect_ready = 0; icache_clr_done = 0;
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_value = '0; id_rs2_value = '0;
    fwd_valid = '0; fwd_wen = '0; fwd_data_rdy = '0; fwd_rd = '0; fwd_data = '0;

    // Reset with an event and a load-use hazard present: flush/id_stall forced low
    ex_valid = 1; ex_jump_flag = 1; id_valid = 1; id_rs1 = 5'd3;
    set_stage(0, 1, 1, 0, 5'd3, 32'h0);
    tick();
    @(negedge clock);
    chk("reset_flush", flush, 0);
    chk("reset_id_stall", id_stall, 0);
    tick();
    reset = 0; clear_ev(); id_valid = 0; set_stage(0, 0, 0, 0, 5'd0, 32'h0);
    @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_redirect_valid", redirect_valid, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_icache_clr_req", icache_clr_req, 0);

    // Jump with zero-wait fetch
    tick();
    ex_valid = 1; ex_jump_flag = 1; ex_jump_target = 32'h8000_0100; redirect_ready = 1;
    @(negedge clock);
    chk("jump_flush", flush, 1);
    chk("jump_rv_before", redirect_valid, 0);
    tick(); clear_ev();
    @(negedge clock);
    chk("jump_rv", redirect_valid, 1);
    chk("jump_pc", redirect_pc, 32'h8000_0100);
    chk("jump_flush_after", flush, 0);
    tick();
    @(negedge clock);
    chk("jump_idle", busy, 0);
    chk("jump_rv_drop", redirect_valid, 0);

    // Jump and taken branch together, fetch stalls 3 cycles
    tick();
    ex_valid = 1; ex_jump_flag = 1; ex_jump_target = 32'h100;
    ex_branch_flag = 1; ex_branch_taken = 1; ex_branch_target = 32'h200; redirect_ready = 0;
    @(negedge clock);
    chk("prio_flush", flush, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clock);
      chk("prio_rv_hold", redirect_valid, 1);
      chk("prio_pc_hold", redirect_pc, 32'h100);
      chk("prio_busy", busy, 1);
      chk("prio_stall", id_stall, 1);
      chk("prio_no_flush", flush, 0);
    end
    tick(); redirect_ready = 1;
    @(negedge clock);
    chk("prio_rv_4th", redirect_valid, 1);
    chk("prio_pc_4th", redirect_pc, 32'h100);
    tick(); clear_ev(); redirect_ready = 0;
    @(negedge clock);
    chk("prio_event_at_handshake_ignored", busy, 0);

    // Stray done while idle, then fence.i with wrap
    tick(); icache_clr_done = 1;
    @(negedge clock);
    chk("stray_done_busy", busy, 0);
    tick(); icache_clr_done = 0;
    ex_valid = 1; ex_fence_i_flag = 1; ex_pc = 32'hFFFF_FFFC; redirect_ready = 1;
    @(negedge clock);
    chk("fence_flush", flush, 1);
    tick(); clear_ev();
    for (int k = 0; k < 5; k++) begin
      if (k == 4) icache_clr_done = 1;
      @(negedge clock);
      chk("fence_icreq", icache_clr_req, 1);
      chk("fence_rv_low", redirect_valid, 0);
      tick();
    end
    icache_clr_done = 0;
    @(negedge clock);
    chk("fence_rv", redirect_valid, 1);
    chk("fence_pc_wrap", redirect_pc, 32'h0);
    chk("fence_icreq_drop", icache_clr_req, 0);
    tick(); redirect_ready = 0;
    @(negedge clock);
    chk("fence_idle", busy, 0);

    // Forwarding priority
    tick();
    id_valid = 1; id_rs1 = 5'd5; id_rs1_value = 32'h11;
    set_stage(0, 1, 1, 1, 5'd5, 32'hAA);
    set_stage(1, 1, 1, 1, 5'd9, 32'hCC);
    set_stage(2, 1, 1, 1, 5'd5, 32'hBB);
    @(negedge clock);
    chk("fwd_youngest", exu_rs1_in, 32'hAA);
    chk("fwd_no_stall", id_stall, 0);
    tick(); fwd_wen[0] = 0;
    @(negedge clock);
    chk("fwd_older", exu_rs1_in, 32'hBB);
    tick(); id_rs1 = 5'd0; id_rs1_value = 32'h55; set_stage(0, 1, 1, 1, 5'd0, 32'hAA);
    @(negedge clock);
    chk("fwd_x0", exu_rs1_in, 32'h55);

    // Load-use on rs2
    tick(); id_rs2 = 5'd7; id_rs2_value = 32'h77; set_stage(0, 1, 1, 0, 5'd7, 32'h0);
    @(negedge clock);
    chk("lu_stall", id_stall, 1);
    chk("lu_rs2_rf", exu_rs2_in, 32'h77);
    tick(); set_stage(0, 1, 1, 1, 5'd7, 32'h1234);
    @(negedge clock);
    chk("lu_release", id_stall, 0);
    chk("lu_rs2_fwd", exu_rs2_in, 32'h1234);
    tick(); fwd_data_rdy[0] = 0; id_valid = 0;
    @(negedge clock);
    chk("lu_no_id_valid", id_stall, 0);
    tick(); fwd_valid = '0; fwd_wen = '0; fwd_data_rdy = '0;

    // Reset during ICFLUSH, done coincident with reset, then a late done
    ex_valid = 1; ex_fence_i_flag = 1; ex_pc = 32'h100;
    @(negedge clock);
    chk("rst_fence_flush", flush, 1);
    tick(); clear_ev();
    @(negedge clock);
    chk("rst_icreq_before", icache_clr_req, 1);
    tick(); reset = 1; icache_clr_done = 1;
    @(negedge clock);
    chk("rst_stall_forced", id_stall, 0);
    tick(); reset = 0; icache_clr_done = 0;
    @(negedge clock);
    chk("rst_icreq", icache_clr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", redirect_pc, 0);
    tick(); icache_clr_done = 1;
    @(negedge clock);
    chk("late_done_busy", busy, 0);
    tick(); icache_clr_done = 0;
    @(negedge clock);
    chk("late_done_no_redirect", redirect_valid, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
